// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM states
// and the step-counter width.
package div_pkg;

  localparam int WA_DEF = 16;
  localparam int WB_DEF = 8;
  localparam int CNT_W  = $clog2(WA_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not underflow.
module div_step
  import div_pkg::*;
#(
  parameter int WB = WB_DEF
) (
  input  logic [WB:0]   p,
  input  logic [WB-1:0] divisor,
  output logic [WB:0]   p_next,
  output logic          qbit
);

  logic [WB:0] divisor_ext;

  assign divisor_ext = {1'b0, divisor};

  always_comb begin
    p_next = p;
    qbit   = 1'b0;
    if (p >= divisor_ext) begin
      p_next = p - divisor_ext;
      qbit   = 1'b1;
    end
  end

endmodule

// File: rtl/div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB
// first, with divide-by-zero short cut and restart-on-start semantics.
module div
  import div_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  input  logic          start,
  output logic [WA-1:0] Q,
  output logic [WB-1:0] R,
  output logic          fin,
  output logic          busy,
  output logic          dz
);

  localparam int CW = (WA == WA_DEF) ? CNT_W : $clog2(WA);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WA-1:0] dvd;
  logic [WB-1:0] dvs;
  logic [WB:0]   p;
  logic [WB:0]   p_shift;
  logic [WB:0]   p_next;
  logic          qbit;

  // Dividend bits leave from the top of dvd while quotient bits enter at the
  // bottom, so after WA steps dvd holds the complete quotient.
  assign p_shift = {p[WB-1:0], dvd[WA-1]};

  div_step #(
    .WB(WB)
  ) u_step (
    .p       (p_shift),
    .divisor (dvs),
    .p_next  (p_next),
    .qbit    (qbit)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      Q     <= '0;
      R     <= '0;
      fin   <= 1'b0;
      busy  <= 1'b0;
      dz    <= 1'b0;
    end else if (start) begin
      dvd <= A;
      dvs <= B;
      p   <= '0;
      cnt <= '0;
      Q   <= '0;
      R   <= '0;
      fin <= 1'b0;
      dz  <= 1'b0;
      if (B == '0) begin
        state <= DONE;
        busy  <= 1'b0;
      end else begin
        state <= CALC;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
        end
        CALC: begin
          p   <= p_next;
          dvd <= {dvd[WA-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WA - 1)) begin
            Q     <= {dvd[WA-2:0], qbit};
            R     <= p_next[WB-1:0];
            fin   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // DONE entered with fin low only happens on a zero divisor: publish
          // the saturated result now, then leave on the following edge.
          if (!fin) begin
            Q   <= '1;
            R   <= '0;
            dz  <= 1'b1;
            fin <= 1'b1;
          end else begin
            fin   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          fin   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the sequential divider.
module tb_div;

  logic        ck;
  logic        rst_n;
  logic [15:0] A;
  logic [7:0]  B;
  logic        start;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        fin;
  logic        busy;
  logic        dz;

  int checks;
  int errors;

  div #(.WA(16), .WB(8)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .start (start),
    .Q     (Q),
    .R     (R),
    .fin   (fin),
    .busy  (busy),
    .dz    (dz)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Load at the edge between two falling edges, then wait for fin.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output int lat, output int busy_n, output logic busy_at_fin);
    @(negedge ck);
    A = a; B = b; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    lat = 0; busy_n = 0; busy_at_fin = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge ck);
      if (fin) begin
        lat = c;
        busy_at_fin = busy;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  initial begin
    int          lat, busy_n, fin_seen;
    logic        baf;
    logic [15:0] ra, eq;
    logic [7:0]  rb, er;
    logic [31:0] prod;

    checks = 0; errors = 0;
    A = '0; B = '0; start = 1'b0;
    rst_n = 1'b1;

    vt[0] = '{16'd200,   8'd7,   16'd28,    8'd4,  1'b0, 16};
    vt[1] = '{16'd65025, 8'd255, 16'd255,   8'd0,  1'b0, 16};
    vt[2] = '{16'd5,     8'd9,   16'd0,     8'd5,  1'b0, 16};
    vt[3] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, 16};
    vt[4] = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,  1'b1, 1};
    vt[5] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0, 16};
    vt[6] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, 16};
    vt[7] = '{16'd1000,  8'd3,   16'd333,   8'd1,  1'b0, 16};
    vt[8] = '{16'd12345, 8'd100, 16'd123,   8'd45, 1'b0, 16};
    vt[9] = '{16'd65534, 8'd254, 16'd258,   8'd2,  1'b0, 16};

    // Reset state
    #3 rst_n = 1'b0;
    #2;
    chk("reset_q", 32'(Q), 0);
    chk("reset_r", 32'(R), 0);
    chk("reset_fin", 32'(fin), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dz", 32'(dz), 0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    repeat (3) @(negedge ck);
    chk("idle_after_reset_busy", 32'(busy), 0);
    chk("idle_after_reset_fin", 32'(fin), 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, lat, busy_n, baf);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_q", i), 32'(Q), 32'(vt[i].q));
      chk($sformatf("v%0d_r", i), 32'(R), 32'(vt[i].r));
      chk($sformatf("v%0d_dz", i), 32'(dz), 32'(vt[i].dz));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), (vt[i].dz ? 0 : 16));
      chk($sformatf("v%0d_busy_at_fin", i), 32'(baf), 0);
      @(negedge ck);
      chk($sformatf("v%0d_fin_drop", i), 32'(fin), 0);
      chk($sformatf("v%0d_q_hold", i), 32'(Q), 32'(vt[i].q));
      chk($sformatf("v%0d_r_hold", i), 32'(R), 32'(vt[i].r));
    end

    // dz holds in idle until the next start clears it
    run_op(16'd1234, 8'd0, lat, busy_n, baf);
    repeat (6) @(negedge ck);
    chk("dz_hold", 32'(dz), 1);
    chk("dz_hold_q", 32'(Q), 32'hFFFF);
    chk("dz_hold_fin", 32'(fin), 0);
    A = 16'd10; B = 8'd2; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    chk("dz_cleared", 32'(dz), 0);
    chk("q_cleared_on_load", 32'(Q), 0);
    chk("busy_after_load", 32'(busy), 1);
    repeat (20) @(negedge ck);
    chk("after_dz_q", 32'(Q), 5);

    // Restart at edge k+5 replaces the operation in flight
    @(negedge ck);
    A = 16'd200; B = 8'd7; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    fin_seen = 0;
    repeat (4) begin
      @(negedge ck);
      if (fin) fin_seen++;
    end
    A = 16'd100; B = 8'd3; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    lat = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge ck);
      if (fin) begin
        lat = c;
        break;
      end
    end
    chk("restart_no_early_fin", 32'(fin_seen), 0);
    chk("restart_lat", 32'(lat), 16);
    chk("restart_q", 32'(Q), 33);
    chk("restart_r", 32'(R), 1);

    // Start held high keeps reloading
    @(negedge ck);
    A = 16'd200; B = 8'd7; start = 1'b1;
    fin_seen = 0;
    repeat (20) begin
      @(negedge ck);
      if (fin) fin_seen++;
    end
    chk("held_start_no_fin", 32'(fin_seen), 0);
    chk("held_start_busy", 32'(busy), 1);
    start = 1'b0;
    lat = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge ck);
      if (fin) begin
        lat = c;
        break;
      end
    end
    chk("held_release_lat", 32'(lat), 16);
    chk("held_release_q", 32'(Q), 28);

    // Asynchronous reset mid-operation
    @(negedge ck);
    A = 16'd200; B = 8'd7; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (7) @(negedge ck);
    @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_fin", 32'(fin), 0);
    chk("midrst_q", 32'(Q), 0);
    chk("midrst_r", 32'(R), 0);
    chk("midrst_dz", 32'(dz), 0);
    @(negedge ck);
    rst_n = 1'b1;
    fin_seen = 0;
    busy_n = 0;
    repeat (30) begin
      @(negedge ck);
      if (fin) fin_seen++;
      if (busy) busy_n++;
    end
    chk("midrst_no_fin", 32'(fin_seen), 0);
    chk("midrst_stays_idle", 32'(busy_n), 0);

    // Random operands against the division identity
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(1, 255));
      eq = ra / 16'(rb);
      er = 8'(ra % 16'(rb));
      run_op(ra, rb, lat, busy_n, baf);
      prod = 32'(Q) * 32'(rb) + 32'(R);
      chk($sformatf("rnd%0d_lat a=%0d b=%0d", i, ra, rb), 32'(lat), 16);
      chk($sformatf("rnd%0d_q a=%0d b=%0d", i, ra, rb), 32'(Q), 32'(eq));
      chk($sformatf("rnd%0d_r a=%0d b=%0d", i, ra, rb), 32'(R), 32'(er));
      chk($sformatf("rnd%0d_ident a=%0d b=%0d", i, ra, rb),
          32'((prod == 32'(ra)) && (R < rb)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
